div_ctrl: RTL and testbench
===========================

# div_ctrl

Run-time controller for the programmable clock divider. It owns the active divide ratio and produces a one-cycle `tick` enable and a divided square wave `clk_out`. Two requesters share it through a req/ack handshake, and an arbiter decides which one wins. A new ratio takes effect only at a period boundary, so `clk_out` never produces a runt pulse. It sits between software/debug configuration logic and every block that consumes the divided enable.

## Interface
- `W`, default 32: width of divide ratio and counter.
- `RST_DIV`, default 0: active ratio loaded at reset (0 = stopped).
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 2: per-requester request level; held high until the matching `ack` is sampled.
- `div0` in W: ratio offered by requester 0; must be stable while `req[0]` is high.
- `div1` in W: ratio offered by requester 1; must be stable while `req[1]` is high.
- `ack` out 2: registered one-cycle acceptance pulse per requester.
- `tick` out 1: one-cycle enable, once per active period.
- `clk_out` out 1: divided square wave.
- `busy` out 1: high while an accepted ratio is pending and not yet applied.
- `running` out 1: high when the active ratio is non-zero.

## Operation
- Registers:
  - `act_div` (W): the active ratio.
  - `cnt` (W): the period counter.
  - `pend_div` (W) and `pend_v`: the pending ratio and its valid flag.
  - `last_gnt`: records the last requester granted.
- States:
  - STOP: `act_div==0`.
  - RUN: `act_div!=0`.
  - The state is derived from `act_div`; there is no separate state register.
- Acceptance:
  - Allowed at an edge when `pend_v==0` and `ack==0`.
  - The winner's div is latched into `pend_div`, `pend_v` is set, and the winner's `ack` bit pulses high for the following cycle.
  - The `ack==0` condition prevents re-accepting a request that is still high during its ack cycle.
- Arbitration (default round-robin):
  - If only one requester is active, that requester wins.
  - If both are active, the requester not equal to `last_gnt` wins.
  - `last_gnt` resets to 1, so requester 0 wins the first tie.
- Apply:
  - In STOP, the pending ratio is applied at the first edge after `pend_v` is set.
  - In RUN, it is applied at the edge ending the cycle with `cnt==act_div-1`.
  - On apply: `act_div<=pend_div`, `cnt<=0`, `pend_v<=0`.
- Counting in RUN:
  - `cnt` increments each cycle and wraps from `act_div-1` to 0.
  - `tick` is high in the cycle with `cnt==act_div-1`.
  - `clk_out` is high while `cnt < act_div>>1` (floor), otherwise low. For odd N the high phase is floor(N/2) cycles and the low phase is ceil(N/2) cycles.
- N=1: `tick` is high every cycle and `clk_out` is held 0.
- Applying 0 enters STOP: `cnt` holds 0, `tick=0`, `clk_out=0`.
- Reset:
  - `act_div=RST_DIV`, `cnt=0`, `pend_v=0`, `last_gnt=1`.
  - `ack=0`, `busy=0`, `tick=0`.
  - `clk_out=0` when `RST_DIV<2`, else 1.
  - `running=(RST_DIV!=0)`.
- Reset asserted mid-period or with a pending ratio discards the pending value. No ack is lost, because an ack is issued only on acceptance.
- Simultaneous apply and new request in the same cycle: the request is not accepted at that edge (`pend_v` still 1). It becomes eligible at the next edge.
- Outputs `tick`, `clk_out`, `busy`, `running` are decoded only from registers, so they are glitch-free.

## Timing
- Acceptance latency: `ack` is high in cycle T+1 when `req` is first high in cycle T with the block idle.
- STOP→RUN: the pending ratio is applied at edge T+1. Cycle T+2 has `cnt=0`, with `clk_out=1` if N≥2.
- RUN change: the new ratio begins at the cycle after the current period's `tick`. Worst-case apply latency is `act_div` cycles after acceptance.
- `busy` rises with `ack` and falls in the first cycle of the new period.
- Throughput: at most one accepted request per active period, and at least 2 cycles between acks.

## Configuration
- `DIV_CTRL_FIXED_PRIO_EN`:
  - Defined: arbitration is fixed priority, and requester 0 always wins ties; `last_gnt` is not implemented.
  - Undefined: round-robin as above.
  - Handshake, apply and timing rules are identical in both builds.

## Test plan
- Reset with `RST_DIV=0`, no requests → `tick=0`, `clk_out=0`, `running=0`, `ack=00` for 20 cycles.
- `req[0]` with `div0=4` from STOP → `ack=01` one cycle later, then `clk_out` repeats 1,1,0,0 with `tick` on every 4th cycle.
- Running N=4 at `cnt=1`, `req[1]` with `div1=5` accepted → N=4 period completes, then 5-cycle periods with `clk_out` pattern 1,1,0,0,0 and `busy` high in between.
- Both requests together (div0=6, div1=3) from STOP → `ack[0]` first, `ack[1]` only after the 6 has been applied; with `DIV_CTRL_FIXED_PRIO_EN` and `req[0]` re-raised immediately, requester 0 wins again.
- Running N=3, apply `div0=0` → after the current `tick`, `clk_out=0`, `tick=0`, `running=0`. Then apply `div1=1` → `tick` constantly high.
- `rst_n` pulsed low while `busy=1` at N=8 → pending value discarded, `act_div=RST_DIV`, `busy=0`, no further ack or ratio change without a new request.

Source files
------------

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: request/acknowledge bundle shared by the two ratio requesters
// and the divider controller. Each requester drives one req bit and offers
// its ratio on its own div lane; the controller answers with a one-cycle ack.
interface div_ctrl_if #(
  parameter int W = 32
);
  logic [1:0]   req;
  logic [W-1:0] div0;
  logic [W-1:0] div1;
  logic [1:0]   ack;

  modport master (output req, output div0, output div1, input ack);
  modport slave  (input req, input div0, input div1, output ack);
endinterface

// File: rtl/div_ctrl.sv
// div_ctrl: run-time controller for the programmable clock divider.
// Owns the active divide ratio, emits a one-cycle tick per period and a
// divided square wave. New ratios are accepted through a req/ack handshake
// and applied only at a period boundary so clk_out never produces a runt.
// Build option: define DIV_CTRL_FIXED_PRIO_EN for fixed-priority arbitration
// (requester 0 always wins ties); otherwise arbitration is round-robin.
module div_ctrl #(
  parameter int          W       = 32,
  parameter int unsigned RST_DIV = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  div_ctrl_if.slave  bus,
  output logic       tick,
  output logic       clk_out,
  output logic       busy,
  output logic       running
);

  localparam logic [W-1:0] RST_DIV_W = W'(RST_DIV);

  // STOP/RUN is a pure decode of the active ratio; no separate state flop.
  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  logic [W-1:0] act_div_reg,  act_div_next;
  logic [W-1:0] cnt_reg,      cnt_next;
  logic [W-1:0] pend_div_reg, pend_div_next;
  logic         pend_v_reg,   pend_v_next;
  logic [1:0]   ack_reg,      ack_next;
`ifndef DIV_CTRL_FIXED_PRIO_EN
  logic         last_gnt_reg, last_gnt_next;
`endif

  state_t state;
  logic   at_end;
  logic   grant1;
  logic   accept;

  assign state  = (act_div_reg == '0) ? ST_STOP : ST_RUN;
  assign at_end = (cnt_reg == act_div_reg - 1'b1);

  // Pick the winner among active requesters.
`ifdef DIV_CTRL_FIXED_PRIO_EN
  assign grant1 = bus.req[1] & ~bus.req[0];
`else
  assign grant1 = bus.req[1] & (~bus.req[0] | ~last_gnt_reg);
`endif

  // A request is taken only with the pending slot empty and no ack in
  // flight, so a req still high during its own ack cycle is not re-taken.
  assign accept = ~pend_v_reg & (ack_reg == 2'b00) & (|bus.req);

  // State register: every controller flop, async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_div_reg  <= RST_DIV_W;
      cnt_reg      <= '0;
      pend_div_reg <= '0;
      pend_v_reg   <= 1'b0;
      ack_reg      <= 2'b00;
`ifndef DIV_CTRL_FIXED_PRIO_EN
      last_gnt_reg <= 1'b1;
`endif
    end else begin
      act_div_reg  <= act_div_next;
      cnt_reg      <= cnt_next;
      pend_div_reg <= pend_div_next;
      pend_v_reg   <= pend_v_next;
      ack_reg      <= ack_next;
`ifndef DIV_CTRL_FIXED_PRIO_EN
      last_gnt_reg <= last_gnt_next;
`endif
    end
  end

  // Next-state: period counting, ratio apply at boundary, request accept.
  always_comb begin
    act_div_next  = act_div_reg;
    cnt_next      = cnt_reg;
    pend_div_next = pend_div_reg;
    pend_v_next   = pend_v_reg;
    ack_next      = 2'b00;
`ifndef DIV_CTRL_FIXED_PRIO_EN
    last_gnt_next = last_gnt_reg;
`endif

    case (state)
      ST_STOP: begin
        cnt_next = '0;
        if (pend_v_reg) begin
          act_div_next = pend_div_reg;
          pend_v_next  = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_next = at_end ? '0 : cnt_reg + 1'b1;
        if (pend_v_reg && at_end) begin
          act_div_next = pend_div_reg;
          pend_v_next  = 1'b0;
        end
      end
      default: cnt_next = '0;
    endcase

    // Accept and apply are exclusive: apply needs pend_v set, accept clear.
    if (accept) begin
      pend_div_next = grant1 ? bus.div1 : bus.div0;
      pend_v_next   = 1'b1;
      ack_next      = grant1 ? 2'b10 : 2'b01;
`ifndef DIV_CTRL_FIXED_PRIO_EN
      last_gnt_next = grant1;
`endif
    end
  end

  // Outputs decode registers only, so none of them can glitch.
  assign running = (state == ST_RUN);
  assign tick    = running & at_end;
  assign clk_out = (cnt_reg < (act_div_reg >> 1));
  assign busy    = pend_v_reg;
  assign bus.ack = ack_reg;

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl with hand-computed expectations.
// Observed vector per cycle is {tick, clk_out, running, busy, ack[1:0]}.
module tb_div_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick, clk_out, busy, running;
  logic [5:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  div_ctrl_if #(.W(W)) bus ();

  div_ctrl #(.W(W), .RST_DIV(0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .tick    (tick),
    .clk_out (clk_out),
    .busy    (busy),
    .running (running)
  );

  always #5 clk = ~clk;

  assign obs = {tick, clk_out, running, busy, bus.ack};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got[5:0], exp[5:0]);
    end else begin
      $display("ok   %s: %b", tag, got[5:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks `cycles` running cycles starting at cnt=0; bit k of the patterns
  // is the expected clk_out/tick at cnt=k.
  task automatic check_run(input string tag, input int n, input logic [15:0] clk_pat,
                           input logic [15:0] tick_pat, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      check($sformatf("%s[%0d]", tag, k), {26'd0, obs},
            {26'd0, tick_pat[k % n], clk_pat[k % n], 1'b1, 1'b0, 2'b00});
      step();
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    check("rst_async", {26'd0, obs}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    bus.req  = 2'b00;
    bus.div0 = '0;
    bus.div1 = '0;
    repeat (3) step();
    rst_n = 1'b1;

    // Idle after reset with RST_DIV=0: everything quiet.
    for (int i = 0; i < 20; i++) begin
      check($sformatf("idle[%0d]", i), {26'd0, obs}, 32'd0);
      step();
    end

    // Requester 0 sets N=4 from STOP.
    bus.req = 2'b01; bus.div0 = 4;
    step();
    check("acc4", {26'd0, obs}, {26'd0, 6'b0_0_0_1_01});
    bus.req = 2'b00;
    step();
    check_run("n4", 4, 16'b0011, 16'b1000, 8);

    // At cnt=1 requester 1 offers N=5; N=4 period completes first.
    step();
    bus.req = 2'b10; bus.div1 = 5;
    step();
    check("acc5", {26'd0, obs}, {26'd0, 6'b0_0_1_1_10});
    bus.req = 2'b00;
    step();
    check("n4_last", {26'd0, obs}, {26'd0, 6'b1_0_1_1_00});
    step();
    check_run("n5", 5, 16'b00011, 16'b10000, 10);

    // Both request from STOP: 0 wins the first tie, 1 after the 6 applies.
    pulse_reset();
    bus.req = 2'b11; bus.div0 = 6; bus.div1 = 3;
    step();
    check("tie_ack0", {26'd0, obs}, {26'd0, 6'b0_0_0_1_01});
    bus.req = 2'b10;
    step();
    check("apply6", {26'd0, obs}, {26'd0, 6'b0_1_1_0_00});
    step();
    check("ack1", {26'd0, obs}, {26'd0, 6'b0_1_1_1_10});
    bus.req = 2'b00;
    step();
    check("n6_c2", {26'd0, obs}, {26'd0, 6'b0_1_1_1_00});
    step();
    check("n6_c3", {26'd0, obs}, {26'd0, 6'b0_0_1_1_00});
    step();
    check("n6_c4", {26'd0, obs}, {26'd0, 6'b0_0_1_1_00});
    step();
    check("n6_c5", {26'd0, obs}, {26'd0, 6'b1_0_1_1_00});
    step();
    check_run("n3", 3, 16'b001, 16'b100, 6);

    // Running N=3, apply 0 -> STOP after the current tick.
    bus.req = 2'b01; bus.div0 = 0;
    step();
    check("acc0", {26'd0, obs}, {26'd0, 6'b0_0_1_1_01});
    bus.req = 2'b00;
    step();
    check("n3_last", {26'd0, obs}, {26'd0, 6'b1_0_1_1_00});
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stop[%0d]", i), {26'd0, obs}, 32'd0);
      step();
    end

    // Apply N=1 from STOP: tick constantly high, clk_out held low.
    bus.req = 2'b10; bus.div1 = 1;
    step();
    check("acc1", {26'd0, obs}, {26'd0, 6'b0_0_0_1_10});
    bus.req = 2'b00;
    step();
    check_run("n1", 1, 16'b0, 16'b1, 5);

    // Go to N=8, make a ratio pending, then reset mid-period.
    bus.req = 2'b01; bus.div0 = 8;
    step();
    check("acc8", {26'd0, obs}, {26'd0, 6'b1_0_1_1_01});
    bus.req = 2'b00;
    step();
    check("apply8", {26'd0, obs}, {26'd0, 6'b0_1_1_0_00});
    step();
    step();
    bus.req = 2'b10; bus.div1 = 3;
    step();
    check("acc3_pend", {26'd0, obs}, {26'd0, 6'b0_1_1_1_10});
    bus.req = 2'b00;
    #1;
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      check($sformatf("post_rst[%0d]", i), {26'd0, obs}, 32'd0);
      step();
    end

    // Tie with requester 0 held high across its own grant.
    bus.req = 2'b11; bus.div0 = 6; bus.div1 = 3;
    step();
    check("tie2_ack0", {26'd0, obs}, {26'd0, 6'b0_0_0_1_01});
    step();
    check("tie2_apply6", {26'd0, obs}, {26'd0, 6'b0_1_1_0_00});
    step();
`ifdef DIV_CTRL_FIXED_PRIO_EN
    check("tie2_second", {26'd0, obs}, {26'd0, 6'b0_1_1_1_01});
`else
    check("tie2_second", {26'd0, obs}, {26'd0, 6'b0_1_1_1_10});
`endif
    bus.req = 2'b00;
    pulse_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
